out_seq: RTL and testbench



---
 rtl/out_seq_pkg.sv | 24 ++
 rtl/seq_mac.sv | 43 ++++
 rtl/out_seq.sv | 137 +++++++++++++
 tb/tb_out_seq.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_seq_pkg.sv
// Shared types and helpers for the out_seq output neuron: FSM states,
// accumulator width and saturation limits.
package out_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // One extra bit beyond clog2 growth keeps the signed sum of NUM_IN full products exact.
  function automatic int acc_width(input int width, input int num_in);
    return 2 * width + $clog2(num_in) + 1;
  endfunction

  function automatic longint sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/seq_mac.sv
// Single-multiplier accumulator for out_seq: selects element idx of the packed
// h/w vectors, multiplies at full width and accumulates under clear/enable.
module seq_mac
  import out_seq_pkg::*;
#(
  parameter int NUM_IN = 2,
  parameter int WIDTH  = 32,
  parameter int ACC_W  = acc_width(WIDTH, NUM_IN),
  parameter int IDX_W  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    en,
  input  logic [IDX_W-1:0]        idx,
  input  logic [NUM_IN*WIDTH-1:0] h,
  input  logic [NUM_IN*WIDTH-1:0] w,
  output logic [ACC_W-1:0]        acc_next
);

  logic signed [WIDTH-1:0]   h_sel;
  logic signed [WIDTH-1:0]   w_sel;
  logic signed [2*WIDTH-1:0] prod;
  logic        [ACC_W-1:0]   acc;

  always_comb begin
    h_sel    = h[int'(idx)*WIDTH +: WIDTH];
    w_sel    = w[int'(idx)*WIDTH +: WIDTH];
    prod     = h_sel * w_sel;
    acc_next = acc + ACC_W'(prod);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/out_seq.sv
// Time-multiplexed output neuron: NUM_IN-cycle MAC, bias add, Q-format rescale
// and saturation, valid/ready on both sides. OUT_SEQ_RELU_EN clamps negatives to 0.
//
// state | meaning
// IDLE  | ready for a bundle; accept registers h/w/b and clears acc
// MAC   | one product per cycle; result registered on the last index
// OUT   | o_valid held until downstream takes the result
module out_seq
  import out_seq_pkg::*;
#(
  parameter int NUM_IN = 2,
  parameter int WIDTH  = 32,
  parameter int FRAC   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] i_h,
  input  logic [NUM_IN*WIDTH-1:0] i_w,
  input  logic [WIDTH-1:0]        i_b,
  input  logic                    i_valid,
  output logic                    i_ready,
  output logic [WIDTH-1:0]        o,
  output logic                    o_valid,
  input  logic                    o_ready
);

  localparam int ACC_W = acc_width(WIDTH, NUM_IN);
  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_max(WIDTH));
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_min(WIDTH));

  state_t state, state_next;

  logic [NUM_IN*WIDTH-1:0] h_q;
  logic [NUM_IN*WIDTH-1:0] w_q;
  logic signed [WIDTH-1:0] b_q;
  logic [IDX_W-1:0]        idx;
  logic                    last;
  logic                    mac_clear;
  logic                    mac_en;
  logic [ACC_W-1:0]        acc_next;

  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] shifted;
  logic        [WIDTH-1:0] res;

  seq_mac #(
    .NUM_IN (NUM_IN),
    .WIDTH  (WIDTH),
    .ACC_W  (ACC_W),
    .IDX_W  (IDX_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .clear    (mac_clear),
    .en       (mac_en),
    .idx      (idx),
    .h        (h_q),
    .w        (w_q),
    .acc_next (acc_next)
  );

  assign last = (idx == LAST_IDX);

  always_comb begin
    state_next = state;
    mac_clear  = 1'b0;
    mac_en     = 1'b0;
    i_ready    = 1'b0;
    o_valid    = 1'b0;
    case (state)
      IDLE: begin
        i_ready = 1'b1;
        if (i_valid) begin
          mac_clear  = 1'b1;
          state_next = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (last) state_next = OUT;
      end
      OUT: begin
        o_valid = 1'b1;
        if (o_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Result is built from acc_next so it lands in the same edge as the last product.
  always_comb begin
    sum     = $signed(acc_next) + (ACC_W'(b_q) <<< FRAC);
    shifted = sum >>> FRAC;
    if (shifted > SAT_HI) begin
      res = SAT_HI[WIDTH-1:0];
    end else if (shifted < SAT_LO) begin
      res = SAT_LO[WIDTH-1:0];
    end else begin
      res = shifted[WIDTH-1:0];
    end
`ifdef OUT_SEQ_RELU_EN
    if (res[WIDTH-1]) res = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      h_q <= '0;
      w_q <= '0;
      b_q <= '0;
      idx <= '0;
      o   <= '0;
    end else begin
      if (mac_clear) begin
        h_q <= i_h;
        w_q <= i_w;
        b_q <= i_b;
        idx <= '0;
      end
      if (mac_en) begin
        idx <= last ? '0 : idx + 1'b1;
        if (last) o <= res;
      end
    end
  end

endmodule

// File: tb/tb_out_seq.sv
// Bench for out_seq: directed cases plus randomized traffic, all checked
// against a cycle-level behavioural model of the handshake and the arithmetic.
module tb_out_seq;

  localparam int NUM_IN = 2;
  localparam int WIDTH  = 32;
  localparam int FRAC   = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] i_h, i_w;
  logic [31:0] i_b;
  logic        i_valid, i_ready;
  logic [31:0] o;
  logic        o_valid, o_ready;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  out_seq #(.NUM_IN(NUM_IN), .WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_h     (i_h),
    .i_w     (i_w),
    .i_b     (i_b),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .o       (o),
    .o_valid (o_valid),
    .o_ready (o_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Exact weighted sum in wide arithmetic, floor-divide by 2^FRAC, clamp.
  function automatic logic [31:0] model_out(input logic [63:0] h, input logic [63:0] w,
                                            input logic [31:0] b);
    logic signed [127:0] s, hk, wk, bk;
    s = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      hk = $signed(h[k*WIDTH +: WIDTH]);
      wk = $signed(w[k*WIDTH +: WIDTH]);
      s  = s + hk * wk;
    end
    bk = $signed(b);
    s  = s + bk * (128'sd1 <<< FRAC);
    s  = s >>> FRAC;
`ifdef OUT_SEQ_RELU_EN
    if (s < 0) return 32'h0;
`endif
    if (s > 128'sd2147483647) return 32'h7FFFFFFF;
    if (s < -128'sd2147483648) return 32'h80000000;
    return s[31:0];
  endfunction

  // Behavioural model of the block: idle/busy, result due NUM_IN+1 cycles after accept.
  bit          mon_en = 1'b0;
  bit          busy   = 1'b0;
  bit          exp_v;
  int          vcyc   = 0;
  logic [31:0] pend   = '0;
  logic [31:0] last_o = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      exp_v = busy && (cyc >= vcyc);
      check("i_ready", i_ready, !busy);
      check("o_valid", o_valid, exp_v);
      check("o", o, exp_v ? pend : last_o);
    end
    if (!rst) begin
      busy   = 1'b0;
      last_o = '0;
    end else if (!busy) begin
      if (i_valid) begin
        busy = 1'b1;
        vcyc = cyc + NUM_IN + 1;
        pend = model_out(i_h, i_w, i_b);
      end
    end else if (cyc >= vcyc && o_ready) begin
      busy   = 1'b0;
      last_o = pend;
    end
  end

  task automatic send(input logic [63:0] h, input logic [63:0] w, input logic [31:0] b,
                      output int t_acc);
    bit ok = 1'b0;
    t_acc = -1;
    i_h = h; i_w = w; i_b = b; i_valid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (i_ready) begin ok = 1'b1; t_acc = cyc; end
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    check("accept", ok, 1);
  endtask

  task automatic get(output logic [31:0] r, output int t_out);
    bit ok = 1'b0;
    r = 'x; t_out = -1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (o_valid && o_ready) begin ok = 1'b1; r = o; t_out = cyc; end
    end
    @(posedge clk); #1;
    check("deliver", ok, 1);
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'h7FFFFFFF - $urandom_range(0, 3);
      2:       return 32'h80000000 + $urandom_range(0, 3);
      default: return 32'($urandom_range(0, 1 << 19)) - 32'(1 << 18);
    endcase
  endfunction

  localparam logic [63:0] BH = {32'h00020000, 32'h00010000};
  localparam logic [63:0] BW = {32'h00004000, 32'h00008000};
  localparam logic [31:0] BB = 32'h00004000;

`ifdef OUT_SEQ_RELU_EN
  localparam logic [31:0] EXP_SAT_NEG = 32'h0;
  localparam logic [31:0] EXP_FLOOR   = 32'h0;
`else
  localparam logic [31:0] EXP_SAT_NEG = 32'h80000000;
  localparam logic [31:0] EXP_FLOOR   = 32'hFFFF8000;
`endif

  initial begin
    logic [31:0] r;
    int ta, tb;
    logic [63:0] bh[3], bw[3];
    logic [31:0] bb[3], rv[3];
    int tout[3];
    int sent, got;
    bit acc_now, out_now;

    rst = 1'b0; i_valid = 1'b0; o_ready = 1'b1;
    i_h = '0; i_w = '0; i_b = '0;
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    i_valid = 1'b1;  // must be ignored while in reset
    @(negedge clk);
    check("rst_o", o, 0);
    check("rst_o_valid", o_valid, 0);
    check("rst_i_ready", i_ready, 1);
    @(posedge clk); #1;
    i_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rst_idle_o_valid", o_valid, 0);
    @(posedge clk); #1;

    send(BH, BW, BB, ta);
    get(r, tb);
    check("basic_o", r, 32'h00014000);
    check("basic_latency", tb - ta, 3);

    send({2{32'h7FFFFFFF}}, {2{32'h7FFFFFFF}}, 32'h0, ta);
    get(r, tb);
    check("sat_pos", r, 32'h7FFFFFFF);

    send({2{32'h7FFFFFFF}}, {2{32'h80000001}}, 32'h0, ta);
    get(r, tb);
    check("sat_neg", r, EXP_SAT_NEG);

    send({32'h0, 32'hFFFF8000}, {32'h0, 32'h00010000}, 32'h0, ta);
    get(r, tb);
    check("floor_neg", r, EXP_FLOOR);

    // Backpressure: result held, a waiting bundle is not taken.
    o_ready = 1'b0;
    send(BH, BW, BB, ta);
    for (int n = 0; n < 20 && !o_valid; n++) @(negedge clk);
    @(posedge clk); #1;
    i_h = {2{32'h7FFFFFFF}}; i_w = {2{32'h7FFFFFFF}}; i_b = '0; i_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_o", o, 32'h00014000);
      check("bp_o_valid", o_valid, 1);
      check("bp_i_ready", i_ready, 0);
    end
    @(posedge clk); #1;
    i_valid = 1'b0; o_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_valid", o_valid, 1);
    @(negedge clk);
    check("bp_after_o_valid", o_valid, 0);
    check("bp_after_i_ready", i_ready, 1);
    check("bp_keep_o", o, 32'h00014000);
    @(posedge clk); #1;

    // Reset one cycle into MAC aborts the bundle.
    send(BH, BW, BB, ta);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_o_valid", o_valid, 0);
    check("midrst_o", o, 0);
    check("midrst_i_ready", i_ready, 1);
    @(posedge clk); #1;
    send({32'h0, 32'hFFFF8000}, {32'h0, 32'h00010000}, 32'h0, ta);
    get(r, tb);
    check("midrst_next_o", r, EXP_FLOOR);
    check("midrst_next_latency", tb - ta, 3);

    // Back-to-back with i_valid held high.
    for (int k = 0; k < 3; k++) begin
      bh[k] = {rnd_word(), rnd_word()};
      bw[k] = {rnd_word(), rnd_word()};
      bb[k] = rnd_word();
    end
    sent = 0; got = 0;
    i_h = bh[0]; i_w = bw[0]; i_b = bb[0]; i_valid = 1'b1;
    for (int n = 0; n < 60 && got < 3; n++) begin
      @(negedge clk);
      acc_now = i_valid && i_ready;
      out_now = o_valid && o_ready;
      if (out_now) begin rv[got] = o; tout[got] = cyc; got++; end
      @(posedge clk); #1;
      if (acc_now) begin
        sent++;
        if (sent < 3) begin i_h = bh[sent]; i_w = bw[sent]; i_b = bb[sent]; end
        else i_valid = 1'b0;
      end
    end
    i_valid = 1'b0;
    check("b2b_count", got, 3);
    for (int k = 0; k < got; k++) check("b2b_o", rv[k], model_out(bh[k], bw[k], bb[k]));
    for (int k = 1; k < got; k++) check("b2b_spacing", tout[k] - tout[k-1], NUM_IN + 2);

    // Randomized traffic, stalls and occasional resets; the model checks every cycle.
    acc_now = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      acc_now = i_valid && i_ready && rst;
      @(posedge clk); #1;
      rst     = ($urandom_range(0, 99) != 0);
      o_ready = ($urandom_range(0, 3) != 0);
      if (!i_valid || acc_now) begin
        i_valid = ($urandom_range(0, 2) != 0);
        i_h = {rnd_word(), rnd_word()};
        i_w = {rnd_word(), rnd_word()};
        i_b = rnd_word();
      end
    end
    rst = 1'b1; i_valid = 1'b0; o_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
